// File: rtl/lut_neuron_loader_if.sv
// Config-stream and lookup signals of the programmable neuron LUT.
// The master drives beats and lookups, the slave (the loader) answers.
interface lut_neuron_loader_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 16
);
    // Handshake: a config beat transfers on cycles where cfg_valid & cfg_ready
    // are both high, a lookup on cycles where in_valid & in_ready are both high.
    // Valid must not depend on ready. out_valid is a one-cycle pulse with no
    // back-pressure.
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_W-1:0]    cfg_data;
    logic                cfg_last;
    logic                in_valid;
    logic                in_ready;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;
    logic                loaded;
    logic                cfg_err;

    modport master (
        output cfg_valid, cfg_data, cfg_last, in_valid, in_data,
        input  cfg_ready, in_ready, out_valid, out_data, loaded, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_last, in_valid, in_data,
        output cfg_ready, in_ready, out_valid, out_data, loaded, cfg_err
    );
endinterface

// File: rtl/lut_neuron_loader.sv
// Runtime-loadable neuron lookup table: a beat stream fills the table,
// then input words are looked up with one cycle of latency.
module lut_neuron_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    lut_neuron_loader_if.slave bus,
    output logic [1:0]       dbg_state
);
    localparam int TBITS  = (1 << IN_BITS) * OUT_BITS;
    localparam int NBEATS = TBITS / CFG_W;
    localparam int PW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int TW     = $clog2(TBITS);

    generate
        if (TBITS % CFG_W != 0) begin : g_bad_cfg_w
            $error("lut_neuron_loader: table size must be a multiple of CFG_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_LOAD   = 2'd1,
        S_LOADED = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [PW-1:0]         ptr, ptr_n, cur;
    logic                  acc, wr_en, look;
    logic [TW-1:0]         wbase, rbase;
    logic [TBITS-1:0]      tbl;
    logic                  out_valid_q;
    logic [OUT_BITS-1:0]   out_data_q;

    assign acc   = bus.cfg_valid & bus.cfg_ready;
    // Outside LOAD every beat is treated as beat 0, which restarts the load.
    assign cur   = (state == S_LOAD) ? ptr : '0;
    assign look  = bus.in_valid & bus.in_ready;
    assign wbase = TW'(cur) * TW'(CFG_W);
    assign rbase = TW'(bus.in_data) * TW'(OUT_BITS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_EMPTY;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        wr_en   = 1'b0;
        if (acc) begin
            wr_en = 1'b1;
            if (cur == PW'(NBEATS - 1)) begin
                ptr_n   = '0;
                state_n = bus.cfg_last ? S_LOADED : S_ERR;
            end else if (bus.cfg_last) begin
                ptr_n   = '0;
                state_n = S_ERR;
            end else begin
                ptr_n   = cur + PW'(1);
                state_n = S_LOAD;
            end
        end
    end

    // Table has no reset; validity is carried entirely by the FSM state.
    always_ff @(posedge clk) begin
        if (wr_en) tbl[wbase +: CFG_W] <= bus.cfg_data;
    end

    // Reads the pre-write contents when a beat lands in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= look;
            if (look) out_data_q <= tbl[rbase +: OUT_BITS];
        end
    end

    assign bus.cfg_ready = 1'b1;
    assign bus.in_ready  = (state == S_LOADED);
    assign bus.loaded    = (state == S_LOADED);
    assign bus.cfg_err   = (state == S_ERR);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_lut_neuron_loader.sv
// Directed bench for lut_neuron_loader at default parameters (256 x 1 table,
// 16-bit beats), checking load sequencing, error paths and lookups.
module tb_lut_neuron_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] dbg_state;
    int n_cmp  = 0;
    int n_fail = 0;
    logic [255:0] t_one;
    logic [255:0] t_fn;
    logic [255:0] t_inv;

    lut_neuron_loader_if #(.IN_BITS(8), .OUT_BITS(1), .CFG_W(16)) bus ();

    lut_neuron_loader #(.IN_BITS(8), .OUT_BITS(1), .CFG_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic last);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = d;
        bus.cfg_last  = last;
        tick();
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
        bus.cfg_data  = '0;
    endtask

    // Sends nb beats of table t; cfg_last is raised on beat last_at (-1: never).
    task automatic load(input logic [255:0] t, input int nb, input int last_at);
        for (int n = 0; n < nb; n++) send_beat(t[n*16 +: 16], n == last_at);
    endtask

    task automatic lookup(input string tag, input logic [7:0] a, input logic exp);
        bus.in_valid = 1'b1;
        bus.in_data  = a;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"},  32'(bus.out_data),  32'(exp));
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.cfg_last  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        t_one = '0;
        t_one[4] = 1'b1;
        for (int a = 0; a < 256; a++) t_fn[a] = a[2] & ~a[6];
        t_inv = ~t_fn;

        // Reset values
        repeat (3) tick();
        chk("rst_loaded",    32'(bus.loaded),    32'd0);
        chk("rst_cfg_err",   32'(bus.cfg_err),   32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("rst_state",     32'(dbg_state),     32'd0);
        rst = 1'b1;
        tick();

        // Single-entry table: only entry 4 is set
        load(t_one, 15, -1);
        chk("one_pre_loaded", 32'(bus.loaded), 32'd0);
        chk("one_pre_ready",  32'(bus.in_ready), 32'd0);
        send_beat(t_one[15*16 +: 16], 1'b1);
        chk("one_loaded",   32'(bus.loaded),   32'd1);
        chk("one_in_ready", 32'(bus.in_ready), 32'd1);
        lookup("one_04", 8'h04, 1'b1);
        tick();
        chk("one_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("one_hold_data",  32'(bus.out_data),  32'd1);
        lookup("one_05", 8'h05, 1'b0);
        lookup("one_ff", 8'hFF, 1'b0);

        // Back-to-back sweep over a[2] & ~a[6]
        load(t_fn, 16, 15);
        chk("fn_loaded", 32'(bus.loaded), 32'd1);
        bus.in_valid = 1'b1;
        for (int a = 0; a < 256; a++) begin
            bus.in_data = 8'(a);
            tick();
            chk("sweep_valid", 32'(bus.out_valid), 32'd1);
            chk("sweep_data",  32'(bus.out_data),  32'(t_fn[a]));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("sweep_end_valid", 32'(bus.out_valid), 32'd0);

        // Early cfg_last on beat 7, then a clean load recovers
        load(t_one, 8, 7);
        chk("early_err",      32'(bus.cfg_err),  32'd1);
        chk("early_loaded",   32'(bus.loaded),   32'd0);
        chk("early_in_ready", 32'(bus.in_ready), 32'd0);
        chk("early_state",    32'(dbg_state),    32'd3);
        send_beat(t_one[15:0], 1'b0);
        chk("recover_err_clr", 32'(bus.cfg_err), 32'd0);
        chk("recover_state",   32'(dbg_state),   32'd1);
        for (int n = 1; n < 16; n++) send_beat(t_one[n*16 +: 16], n == 15);
        chk("recover_loaded", 32'(bus.loaded), 32'd1);
        lookup("recover_04", 8'h04, 1'b1);

        // Missing cfg_last: 16 beats with no last
        load(t_fn, 15, -1);
        chk("miss_pre_err", 32'(bus.cfg_err), 32'd0);
        send_beat(t_fn[15*16 +: 16], 1'b0);
        chk("miss_err",    32'(bus.cfg_err), 32'd1);
        chk("miss_loaded", 32'(bus.loaded),  32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h04;
        tick();
        bus.in_valid = 1'b0;
        chk("miss_no_accept", 32'(bus.out_valid), 32'd0);
        chk("miss_hold_data", 32'(bus.out_data),  32'd1);

        // Reload while a lookup is accepted in the same cycle
        load(t_fn, 16, 15);
        chk("a_loaded", 32'(bus.loaded), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h44;
        tick();
        chk("pre_44_data", 32'(bus.out_data), 32'd0);
        bus.in_data   = 8'h04;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = t_inv[15:0];
        bus.cfg_last  = 1'b0;
        tick();
        bus.in_valid  = 1'b0;
        bus.cfg_valid = 1'b0;
        chk("rbw_valid",    32'(bus.out_valid), 32'd1);
        chk("rbw_old_data", 32'(bus.out_data),  32'd1);
        chk("rbw_in_ready", 32'(bus.in_ready),  32'd0);
        chk("rbw_loaded",   32'(bus.loaded),    32'd0);
        for (int n = 1; n < 16; n++) send_beat(t_inv[n*16 +: 16], n == 15);
        chk("b_loaded", 32'(bus.loaded), 32'd1);
        lookup("b_04", 8'h04, 1'b0);
        lookup("b_44", 8'h44, 1'b1);

        // Reset asserted on beat 9 of a load
        load(t_one, 9, -1);
        rst = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = t_one[9*16 +: 16];
        tick();
        bus.cfg_valid = 1'b0;
        chk("mid_rst_loaded",    32'(bus.loaded),    32'd0);
        chk("mid_rst_err",       32'(bus.cfg_err),   32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("mid_rst_state",     32'(dbg_state),     32'd0);
        rst = 1'b1;
        load(t_fn, 15, -1);
        chk("restart_not_done", 32'(bus.loaded), 32'd0);
        send_beat(t_fn[15*16 +: 16], 1'b1);
        chk("restart_loaded", 32'(bus.loaded), 32'd1);
        lookup("restart_05", 8'h05, 1'b1);
        lookup("restart_44", 8'h44, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lut_neuron_loader.md
Name: lut_neuron_loader

Overview:
- Runtime-programmable counterpart to the fixed truth-table neurons: the writer side that fills a neuron lookup table, plus the registered lookup path that reads it.
- A config stream loads a 2^IN_BITS x OUT_BITS table into distributed RAM. Once the table is complete, the block evaluates input words with one-cycle latency.
- Used for in-field reprogramming and for bench checking of generated LUT layers against exported tables.

Parameters:
- IN_BITS, 8, neuron input width; table depth 2^IN_BITS entries.
- OUT_BITS, 1, output width per entry.
- CFG_W, 16, config beat width in table bits; (2^IN_BITS*OUT_BITS) % CFG_W == 0 is required, checked by an elaboration-time assertion.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  config beat accepted when high with cfg_valid.
- cfg_data  in  CFG_W  packed table bits.
- cfg_last  in  1  marks final beat of a load.
- in_valid  in  1  input word valid.
- in_ready  out  1  lookup available.
- in_data  in  IN_BITS  table address (neuron inputs, bit i = input i).
- out_valid  out  1  result valid.
- out_data  out  OUT_BITS  table entry.
- loaded  out  1  table complete and consistent.
- cfg_err  out  1  sticky error from last load attempt.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-low.
- Reset: state EMPTY, beat pointer 0, cfg_ready=1, in_ready=0, out_valid=0, out_data=0, loaded=0, cfg_err=0. Table RAM is not reset.
- NBEATS = 2^IN_BITS*OUT_BITS/CFG_W (16 at defaults). Beat n writes table bits [n*CFG_W +: CFG_W]. Entry a occupies bits [a*OUT_BITS +: OUT_BITS]. cfg_data bit 0 is the lowest table bit of the beat.
- States: EMPTY, LOAD, LOADED, ERR.
- EMPTY, LOADED or ERR, on an accepted beat (cfg_valid & cfg_ready):
  - write beat 0, pointer := 1, loaded := 0, cfg_err := 0.
  - Go to LOAD. If cfg_last is set on this beat (with NBEATS>1), go to ERR instead.
  - Any beat therefore restarts a load, including from LOADED; the old table is invalidated at once.
- LOAD, accepted beat at pointer p:
  - write beat p.
  - If p == NBEATS-1 and cfg_last: go to LOADED, loaded := 1, pointer := 0.
  - If p == NBEATS-1 and !cfg_last: go to ERR (missing last).
  - If p < NBEATS-1 and cfg_last: go to ERR (early last).
  - Otherwise pointer := p+1.
- Entering ERR: cfg_err := 1, loaded := 0, pointer := 0. cfg_err stays high until the next accepted beat.
- cfg_ready is 1 in all states. Beats are never back-pressured; the table write happens in the accept cycle.
- in_ready = (state == LOADED). A lookup is accepted on in_valid & in_ready.
- Accepted lookup: next cycle out_valid=1 and out_data = table[in_data]. No accept: next cycle out_valid=0 and out_data holds its last value.
- Lookups are fully pipelined, one per cycle. Throughput is 1/cycle and there is no output back-pressure.
- Simultaneous lookup accept and config beat in LOADED:
  - the lookup reads the old table contents at that address (read-before-write);
  - out_valid asserts next cycle as normal;
  - in_ready drops the following cycle.
- In-flight result when a reload starts is still delivered, one cycle later.
- Reset mid-load: state returns to EMPTY, and the partially written table is treated as invalid (loaded=0).
- Pointer is log2(NBEATS) bits (minimum 1). It never wraps past NBEATS-1 because of the checks above.

Test Plan:
- Reset then load 16 beats, all zero except beat 0 = 16'h0010 (entry 4 = 1), last on beat 15 -> loaded=1 after the beat-15 accept; lookups 0x04 -> 1, 0x05 -> 0, 0xFF -> 0, each with out_valid exactly one cycle after the accept.
- Back-to-back lookups 0x00..0xFF against a table whose entry a = a[2]&~a[6] -> 256 consecutive out_valid pulses, every result matches, no bubbles.
- cfg_last on beat 7 -> cfg_err=1, loaded=0, in_ready=0; then a clean 16-beat load -> cfg_err clears on its first beat and loaded=1 at the end.
- 16 beats without cfg_last -> cfg_err=1 after beat 15; a lookup attempted afterwards is not accepted (in_ready=0).
- LOADED table A; same cycle: lookup 0x04 plus first beat of table B -> result uses table A value, in_ready=0 the next cycle, loaded=0 until B completes; afterwards 0x04 returns B's value.
- Assert rst low at beat 9 of a load -> next cycle loaded=0, cfg_err=0, out_valid=0, in_ready=0, and the pointer restarts at beat 0.
